regfile: RTL and testbench

Architectural integer register file for the ARM datapath: 32 × 64-bit registers, two combinational read ports, one clocked write port. Sits in decode; read ports feed operand selection, write port is driven by writeback. Register 31 is XZR: always reads zero, writes discarded. Same-cycle write-to-read forwarding lets decode see the writeback value in the cycle it is written.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_register_en.sv | 18 +
 rtl/regfile.sv | 64 ++++++
 tb/tb_regfile.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the architectural integer register file.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;
  localparam int XZR        = 31;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_register_en.sv
// Single register-file entry: WIDTH-bit D register, async active-high clear, sync enable.
module register_en #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

// File: rtl/regfile.sv
// 32 x 64-bit register file: two combinational read ports with same-cycle
// writeback forwarding, one clocked write port, XZR hard-wired to zero.
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]      rd1,
  output logic [WIDTH-1:0]      rd2,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]      wd
);
  localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);

  logic [WIDTH-1:0] entry [NREGS];

  // The zero register has no storage; its slot is tied off so the read mux stays regular.
  for (genvar i = 0; i < NREGS; i++) begin : g_entry
    if (i == ZERO_REG) begin : g_zero
      assign entry[i] = '0;
    end else begin : g_reg
      logic en;
      assign en = we & (wa == reg_addr_t'(i)) & ~reset;

      register_en #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (wd),
        .q     (entry[i])
      );
    end
  end

  // Forwarding is suppressed under reset so the outputs track the async clear.
  always_comb begin
    rd1 = '0;
    if (!reset && ra1 != ZERO_ADDR) begin
      if (we && wa == ra1) begin
        rd1 = wd;
      end else begin
        rd1 = entry[ra1];
      end
    end
  end

  always_comb begin
    rd2 = '0;
    if (!reset && ra2 != ZERO_ADDR) begin
      if (we && wa == ra2) begin
        rd2 = wd;
      end else begin
        rd2 = entry[ra2];
      end
    end
  end
endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: vector table for writes, reads and forwarding,
// plus hand-written sequences for reset under write and mid-cycle async reset.
module tb_regfile;
  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic [4:0]   ra1;
  logic [4:0]   ra2;
  logic [W-1:0] rd1;
  logic [W-1:0] rd2;
  logic         we;
  logic [4:0]   wa;
  logic [W-1:0] wd;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic         we;
    logic [4:0]   wa;
    logic [W-1:0] wd;
    logic [4:0]   ra1;
    logic [4:0]   ra2;
    logic [W-1:0] exp1;
    logic [W-1:0] exp2;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  regfile dut (
    .clk   (clk),
    .reset (reset),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (we),
    .wa    (wa),
    .wd    (wd)
  );

  // clock / reset: 10 ns period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=0x%016h required=0x%016h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v_we, input logic [4:0] v_wa, input logic [W-1:0] v_wd,
                       input logic [4:0] v_ra1, input logic [4:0] v_ra2);
    we  = v_we;
    wa  = v_wa;
    wd  = v_wd;
    ra1 = v_ra1;
    ra2 = v_ra2;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // {we, wa, wd, ra1, ra2, exp1, exp2}; each vector occupies one cycle,
    // checked before the edge that commits its write.
    vecs[0]  = '{1'b1, 5'd3,  64'd527,                 5'd3,  5'd4,  64'd527,                 64'd0};
    vecs[1]  = '{1'b1, 5'd4,  64'hFFFF_FFFF_FFFF_FFF8, 5'd3,  5'd4,  64'd527,                 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[2]  = '{1'b0, 5'd0,  64'd0,                   5'd3,  5'd4,  64'd527,                 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[3]  = '{1'b1, 5'd7,  64'd18,                  5'd7,  5'd6,  64'd18,                  64'd0};
    vecs[4]  = '{1'b1, 5'd7,  64'h3456_789A_BCDE_F012, 5'd7,  5'd6,  64'h3456_789A_BCDE_F012, 64'd0};
    vecs[5]  = '{1'b0, 5'd7,  64'd0,                   5'd7,  5'd6,  64'h3456_789A_BCDE_F012, 64'd0};
    vecs[6]  = '{1'b1, 5'd31, 64'd981,                 5'd31, 5'd31, 64'd0,                   64'd0};
    vecs[7]  = '{1'b0, 5'd0,  64'd0,                   5'd31, 5'd30, 64'd0,                   64'd0};
    vecs[8]  = '{1'b1, 5'd30, 64'd981,                 5'd31, 5'd30, 64'd0,                   64'd981};
    vecs[9]  = '{1'b0, 5'd0,  64'd0,                   5'd30, 5'd30, 64'd981,                 64'd981};
    vecs[10] = '{1'b1, 5'd9,  64'd100,                 5'd9,  5'd9,  64'd100,                 64'd100};
    vecs[11] = '{1'b1, 5'd10, 64'd55,                  5'd9,  5'd9,  64'd100,                 64'd100};
    vecs[12] = '{1'b1, 5'd9,  64'd200,                 5'd9,  5'd9,  64'd200,                 64'd200};
    vecs[13] = '{1'b0, 5'd0,  64'd0,                   5'd10, 5'd9,  64'd55,                  64'd200};
    vecs[14] = '{1'b1, 5'd0,  64'd1,                   5'd0,  5'd1,  64'd1,                   64'd0};
    vecs[15] = '{1'b0, 5'd0,  64'd0,                   5'd0,  5'd1,  64'd1,                   64'd0};

    // reset held across an edge with a write pending: write must be lost
    reset = 1'b1;
    drive(1'b1, 5'd5, 64'd77, 5'd5, 5'd0);
    #1;
    check("reset_rd1_no_fwd", rd1, 64'd0);
    check("reset_rd2", rd2, 64'd0);
    @(posedge clk);
    #2;
    check("reset_after_edge_rd1", rd1, 64'd0);
    reset = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 5'd5, 5'd0);
    @(posedge clk);
    #2;
    check("post_reset_x5", rd1, 64'd0);
    check("post_reset_x0", rd2, 64'd0);

    // table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #2;
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
      #1;
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].exp2);
    end

    // forwarded value must not glitch at the write edge
    @(posedge clk);
    #2;
    drive(1'b1, 5'd12, 64'hA5A5_0000_1234_5678, 5'd12, 5'd12);
    @(negedge clk);
    check("fwd_pre_edge", rd1, 64'hA5A5_0000_1234_5678);
    @(posedge clk);
    #0.1;
    check("fwd_at_edge", rd2, 64'hA5A5_0000_1234_5678);
    we = 1'b0;
    #1;
    check("fwd_from_storage", rd1, 64'hA5A5_0000_1234_5678);

    // async reset between edges, release 2 ns before next edge with a write
    @(posedge clk);
    #1;
    drive(1'b1, 5'd2, 64'd345, 5'd2, 5'd3);
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    check("x2_before_async", rd1, 64'd345);
    #1;
    reset = 1'b1;
    #1;
    check("async_clear_x2", rd1, 64'd0);
    check("async_clear_x3", rd2, 64'd0);
    #4;
    reset = 1'b0;
    drive(1'b1, 5'd2, 64'd4, 5'd2, 5'd9);
    #1;
    check("release_fwd_x2", rd1, 64'd4);
    check("release_x9_cleared", rd2, 64'd0);
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    check("release_write_x2", rd1, 64'd4);
    ra2 = 5'd30;
    #1;
    check("async_clear_x30", rd2, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
